cpu_multicycle: RTL
===================

# cpu_multicycle

Parametrised multi-cycle RV32 integer core, successor to the single-cycle addi-only datapath. It adds a request/valid instruction-fetch handshake tolerant of variable memory latency, the full RV32I ALU/jump/branch subset, a selectable register count (RV32I/RV32E), retire reporting and a halt on illegal or misaligned execution. It sits at the top of the CPU hierarchy and drives instruction memory directly. There is no data-memory port: loads, stores, FENCE and SYSTEM are out of scope.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `NUM_REGS`, default 32: GPR count. Legal values are 32 (RV32I) or 16 (RV32E).
- `i_clock` input 1: sole clock, rising edge.
- `i_reset` input 1: asynchronous, active-high reset.
- `o_imemReq` output 1: fetch request, held high until accepted.
- `o_imemAddr` output 32: fetch address, equal to the PC. Stable while `o_imemReq` is high.
- `i_imemValid` input 1: `i_imemData` is valid this cycle; completes the fetch.
- `i_imemData` input 32: instruction word.
- `o_retire` output 1: one-cycle pulse per retired instruction.
- `o_retirePC` output 32: PC of the retired instruction. Valid when `o_retire` is high.
- `o_halt` output 1: core halted. Sticky until reset.

## Operation
- The FSM has three states: FETCH, EXEC and HALT.
- **FETCH**
  - `o_imemReq`=1 and `o_imemAddr`=PC.
  - When `i_imemValid`=1, capture `i_imemData` into IR and go to EXEC.
  - `i_imemValid` is ignored in every state other than FETCH.
- **EXEC** (exactly one cycle)
  - Decode IR, read rs1/rs2, compute the result, write rd, update PC, pulse `o_retire`, then go to FETCH.
- **Supported instructions**
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- **Arithmetic rules**
  - All arithmetic is 32-bit modulo.
  - Shift amount is bits [4:0].
  - Immediates are sign-extended per RISC-V I/S/B/U/J formats.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
- **Next PC**
  - Default: PC+4.
  - JAL: PC+immJ.
  - JALR: (rs1+immI) with bit 0 cleared.
  - Taken branch: PC+immB.
  - JAL/JALR write rd = old PC+4.
- **x0**
  - Writes to x0 are discarded; x0 always reads 0.
- **Illegal instructions.** Any of the following sends the FSM to HALT without retiring, without writing rd, and with PC left unchanged:
  - Unsupported opcode.
  - Unsupported funct3/funct7 combination.
  - Any of rd/rs1/rs2 ≥ `NUM_REGS`. For I-type, U-type and J-type instructions, only the fields those formats actually use are checked.
- **Misaligned target.** A computed next-PC with bit 1 set, on a taken jump or taken branch, also goes to HALT with no write and no retire. The PC stays at the faulting instruction.
- **HALT**
  - `o_halt`=1, `o_imemReq`=0.
  - Only reset leaves HALT.

## Timing
- **Reset values** (applied asynchronously):
  - state=FETCH, PC=`RESET_PC`, IR=0.
  - All GPRs=0.
  - `o_imemReq`=0, `o_retire`=0, `o_retirePC`=0, `o_halt`=0.
- **Request timing**
  - `o_imemReq` is a registered state decode. It rises on the first clock edge after `i_reset` falls.
- **Fetch latency**
  - Minimum is 1 cycle: `i_imemValid` may be high in the first request cycle.
  - Waiting is unbounded: the request and address stay held.
- **Instruction throughput**
  - Minimum 2 cycles per instruction.
  - `o_retire`/`o_retirePC` are registered and high in the cycle after EXEC, which is the first cycle of the next FETCH.
- **Register file**
  - The register-file write in EXEC is visible to the next instruction's EXEC; no bypass is needed.
- **Reset mid-operation**
  - Reset during FETCH or EXEC aborts immediately.
  - A pending `i_imemValid` arriving during or after reset is ignored until a new request is issued.

## Structure
- Package `cpu_pkg` holds:
  - Opcode localparams: OP_IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH.
  - funct3/funct7 constants.
  - `state_t` enum {FETCH, EXEC, HALT}.
  - `alu_op_t` enum.
- Sub-module `cpu_regfile`:
  - Parametrised by `NUM_REGS`.
  - Two combinational read ports and one synchronous write port.
  - x0 hardwired to 0; async reset clears all registers.
- Decode, ALU and branch compare stay in `cpu_multicycle`, as combinational logic on IR.

## Test plan
- **Basic ALU.** Reset with `RESET_PC`=0 and zero-latency imem. Program: `0x00500093` (addi x1,x0,5), then `0x00108133` (add x2,x1,x1). Required: x1=5, x2=10; retire pulses with PCs 0 and 4, 2 cycles apart.
- **Upper immediate and jump.** Program: `0x123451B7` (lui x3,0x12345) at PC 0, then `0x008000EF` (jal x1,8) at PC 4. Required: x3=0x12345000, x1=8; the next fetch address is 0xC.
- **Fetch stall.** Hold `i_imemValid` low for 5 cycles. Required: `o_imemReq`=1 and `o_imemAddr` stable throughout; no retire until 1 cycle after valid.
- **Illegal instruction.** Feed `0x00000000`. Required: `o_halt`=1 from the next cycle, `o_imemReq`=0, no retire, PC unchanged. Also with `NUM_REGS`=16: `0x00100813` (addi x16,x0,1) must halt.
- **Branches.** Set x1=-1, then bltu x0,x1,+8 and blt x0,x1,+8. Required: bltu taken (PC+8), blt not taken (PC+4). A jalr to target 0x6 must halt.
- **Reset mid-fetch.** Assert `i_reset` mid-fetch, while valid is outstanding. Required: all outputs return to reset values at once; the first request after release is at `RESET_PC`; writes to x0 read back 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, function codes, FSM states and ALU helpers for cpu_multicycle
package cpu_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    // alt selects SUB for F3_ADD and SRA for F3_SR
    function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            default:  return a & b;
        endcase
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: GPR file with two async read ports, one sync write port, x0 tied to zero
module cpu_regfile #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [5:0] NR = 6'(NUM_REGS);

    logic [31:0] regs_q [NUM_REGS];

    assign rdata1_o = (raddr1_i != 5'd0 && {1'b0, raddr1_i} < NR) ? regs_q[raddr1_i[AW-1:0]] : 32'd0;
    assign rdata2_o = (raddr2_i != 5'd0 && {1'b0, raddr2_i} < NR) ? regs_q[raddr2_i[AW-1:0]] : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we_i && waddr_i != 5'd0 && {1'b0, waddr_i} < NR) begin
            regs_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: FETCH/EXEC multi-cycle RV32I/E integer core with req/valid fetch,
// retire reporting and a sticky halt on illegal or misaligned execution.
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemValid,
    input  logic [31:0] i_imemData,
    output logic        o_retire,
    output logic [31:0] o_retirePC,
    output logic        o_halt
);

    localparam logic [5:0] NR = 6'(NUM_REGS);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, retire_pc_q, retire_pc_d;
    logic        req_q, retire_q, retire_d, halt_q;

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_b, imm_u, imm_j, pc_plus4;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_res, wb_val, next_pc;
    logic        legal, use_rd, use_rs1, use_rs2, jump, wb, taken, fault, we;

    assign opcode   = ir_q[6:0];
    assign rd       = ir_q[11:7];
    assign f3       = ir_q[14:12];
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign f7       = ir_q[31:25];
    assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_b    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u    = {ir_q[31:12], 12'd0};
    assign imm_j    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign pc_plus4 = pc_q + 32'd4;

    // ir[30] only distinguishes SUB/SRA for OP and SRAI for OP-IMM shifts
    assign alu_res = alu(alu_sel(f3, ir_q[30] && (opcode == OP || f3 == F3_SR)), rs1_val, alu_b);

    // f3[2]: ordered compare, f3[1]: unsigned, f3[0]: invert
    assign taken = f3[0] ^ (f3[2] ? (f3[1] ? rs1_val < rs2_val : $signed(rs1_val) < $signed(rs2_val))
                                  : rs1_val == rs2_val);

    always_comb begin
        legal   = 1'b1;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        jump    = 1'b0;
        wb      = 1'b0;
        alu_b   = imm_i;
        wb_val  = alu_res;
        next_pc = pc_plus4;
        case (opcode)
            OP_IMM: begin
                {use_rd, use_rs1, wb} = 3'b111;
                legal = (f3 == F3_SLL) ? f7 == F7_BASE
                      : (f3 == F3_SR)  ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
            end
            OP: begin
                {use_rd, use_rs1, use_rs2, wb} = 4'b1111;
                alu_b = rs2_val;
                legal = f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
            end
            LUI: begin
                {use_rd, wb} = 2'b11;
                wb_val = imm_u;
            end
            AUIPC: begin
                {use_rd, wb} = 2'b11;
                wb_val = pc_q + imm_u;
            end
            JAL: begin
                {use_rd, wb, jump} = 3'b111;
                wb_val  = pc_plus4;
                next_pc = pc_q + imm_j;
            end
            JALR: begin
                {use_rd, use_rs1, wb, jump} = 4'b1111;
                wb_val  = pc_plus4;
                next_pc = (rs1_val + imm_i) & ~32'd1;
                legal   = f3 == 3'd0;
            end
            BRANCH: begin
                {use_rs1, use_rs2} = 2'b11;
                jump    = taken;
                next_pc = taken ? pc_q + imm_b : pc_plus4;
                legal   = f3[2:1] != 2'b01;
            end
            default: legal = 1'b0;
        endcase
    end

    assign fault = !legal || (jump && next_pc[1])
                 || (use_rd && {1'b0, rd} >= NR) || (use_rs1 && {1'b0, rs1} >= NR)
                 || (use_rs2 && {1'b0, rs2} >= NR);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        retire_d    = 1'b0;
        retire_pc_d = retire_pc_q;
        we          = 1'b0;
        case (state_q)
            FETCH: begin
                // req_q gates acceptance so a stale valid right after reset is dropped
                if (req_q && i_imemValid) begin
                    ir_d    = i_imemData;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (fault) begin
                    state_d = HALT;
                end else begin
                    state_d     = FETCH;
                    pc_d        = next_pc;
                    we          = wb;
                    retire_d    = 1'b1;
                    retire_pc_d = pc_q;
                end
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            req_q       <= 1'b0;
            retire_q    <= 1'b0;
            retire_pc_q <= '0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            req_q       <= state_d == FETCH;
            retire_q    <= retire_d;
            retire_pc_q <= retire_pc_d;
            halt_q      <= state_d == HALT;
        end
    end

    cpu_regfile #(.NUM_REGS(NUM_REGS)) u_rf (
        .clk      (i_clock),
        .rst      (i_reset),
        .we_i     (we),
        .waddr_i  (rd),
        .wdata_i  (wb_val),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rs1_val),
        .rdata2_o (rs2_val)
    );

    assign o_imemReq  = req_q;
    assign o_imemAddr = pc_q;
    assign o_retire   = retire_q;
    assign o_retirePC = retire_pc_q;
    assign o_halt     = halt_q;

endmodule
